// File: rtl/uart_tx.sv
// UART transmitter: one frame per accepted request, start / LSB-first data / optional parity / stop.
// Runs on the baud clock, so every CLK cycle is one bit time on TX_OUT.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  par_acc_q;
  logic                  tx_q;
  logic                  busy_q;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic xor_acc, input logic odd);
    return xor_acc ^ odd;
  endfunction

  // Frame FSM with serializer; outputs are loaded one cycle ahead so they are registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (Data_Valid) begin
            shift_q   <= P_DATA;
            par_en_q  <= parity_enable;
            par_odd_q <= parity_type;
            par_acc_q <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        START: begin
          tx_q      <= shift_q[0];
          par_acc_q <= par_acc_q ^ shift_q[0];
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= '0;
          state_q   <= DATA;
        end
        DATA: begin
          // Parity accumulates each bit as it goes out, so it always reflects the latched word.
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_q <= '0;
            if (par_en_q) begin
              tx_q    <= parity_bit(par_acc_q, par_odd_q);
              state_q <= PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            tx_q      <= shift_q[0];
            par_acc_q <= par_acc_q ^ shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        PARITY: begin
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues per-cycle expected (TX_OUT, busy) and a monitor checks them.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       parity_enable;
  logic       parity_type;
  logic       TX_OUT;
  logic       busy;

  typedef struct {
    logic  tx;
    logic  bsy;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic tx_e, input logic bsy_e);
    vectors++;
    if (TX_OUT !== tx_e || busy !== bsy_e) begin
      miscompares++;
      $display("FAIL %s: got TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
               tag, TX_OUT, busy, tx_e, bsy_e);
    end
  endtask

  // Monitor: one sample per bit time, mid-way between edges.
  always begin
    @(posedge CLK);
    #3;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, e.tx, e.bsy);
    end
  end

  task automatic push(input logic tx, input logic bsy, input string tag);
    exp_t e;
    e.tx = tx; e.bsy = bsy; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, tag);
  endtask

  // Full frame plus the single idle cycle that follows it.
  task automatic push_frame(input logic [7:0] d, input logic pen, input logic pbit, input string tag);
    push(1'b0, 1'b1, {tag, "/start"});
    for (int i = 0; i < 8; i++) push(d[i], 1'b1, $sformatf("%s/d%0d", tag, i));
    if (pen) push(pbit, 1'b1, {tag, "/parity"});
    push(1'b1, 1'b1, {tag, "/stop"});
    push(1'b1, 1'b0, {tag, "/idle"});
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (exp_q.size() != 0 && n < 400);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptype,
                      input logic pbit, input bit disturb, input string tag);
    drain();
    P_DATA = d; parity_enable = pen; parity_type = ptype; Data_Valid = 1'b1;
    push_frame(d, pen, pbit, tag);
    @(negedge CLK);
    Data_Valid = 1'b0;
    if (disturb) begin
      repeat (3) @(negedge CLK);
      P_DATA = ~d; parity_type = ~ptype;
      repeat (2) @(negedge CLK);
      parity_enable = ~pen; P_DATA = 8'h00;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00;
    parity_enable = 1'b0; parity_type = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_state", 1'b1, 1'b0);
    RST = 1'b1;
    push_idle(2, "post_reset_idle");

    // 1: no parity, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "t1_a5_nopar");
    push_idle(2, "t1_after");
    // 2: 0xA5 has four ones
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "t2_a5_even");
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, "t2_a5_odd");
    // 3: 0x07 has three ones, inputs disturbed mid-frame
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, "t3_07_even");
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, "t3_07_odd");

    // 4: request during DATA and STOP must be dropped
    drain();
    P_DATA = 8'h3C; parity_enable = 1'b0; parity_type = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0, "t4_3c");
    push_idle(6, "t4_no_second");
    @(negedge CLK); Data_Valid = 1'b0;
    repeat (3) @(negedge CLK); P_DATA = 8'hFF; Data_Valid = 1'b1;
    @(negedge CLK); Data_Valid = 1'b0;
    repeat (5) @(negedge CLK); Data_Valid = 1'b1;
    @(negedge CLK); Data_Valid = 1'b0;

    // 5: Data_Valid held, three back-to-back frames of 0x55
    drain();
    P_DATA = 8'h55; parity_enable = 1'b0; Data_Valid = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(8'h55, 1'b0, 1'b0, $sformatf("t5_f%0d", f));
    push_idle(3, "t5_tail");
    repeat (30) @(negedge CLK);
    Data_Valid = 1'b0;

    // 6: reset asserted during data bit 3 of 0x81
    drain();
    P_DATA = 8'h81; parity_enable = 1'b0; Data_Valid = 1'b1;
    push(1'b0, 1'b1, "t6_start");
    push(1'b1, 1'b1, "t6_d0");
    push(1'b0, 1'b1, "t6_d1");
    push(1'b0, 1'b1, "t6_d2");
    push(1'b0, 1'b1, "t6_d3");
    @(negedge CLK); Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("t6_async_reset", 1'b1, 1'b0);
    push_idle(2, "t6_in_reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    push_idle(3, "t6_after_release");
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, "t6_resend");
    push_idle(2, "t6_tail");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
